// File: rtl/exe_stage.sv
// Execute pipeline stage: one-entry bundle register between ID and MEM with
// valid/allowin handshake, ALU operand drive, ID bypass and a sticky control-check flag.
module exe_stage #(
  parameter int ALU_CTRL_W = 12,
  parameter int DEST_W     = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  ds_to_es_valid,
  output logic                  es_allowin,
  input  logic [ALU_CTRL_W-1:0] ds_alu_control,
  input  logic [31:0]           ds_src1,
  input  logic [31:0]           ds_src2,
  input  logic [31:0]           ds_pc,
  input  logic [31:0]           ds_store_data,
  input  logic [DEST_W-1:0]     ds_dest,
  input  logic                  ds_gr_we,
  input  logic                  ds_mem_we,
  input  logic                  ds_res_from_mem,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [31:0]           alu_rj,
  output logic [31:0]           alu_rk,
  input  logic [31:0]           alu_result,
  output logic                  es_to_ms_valid,
  input  logic                  ms_allowin,
  output logic [31:0]           es_pc,
  output logic [31:0]           es_result,
  output logic [31:0]           es_store_data,
  output logic [DEST_W-1:0]     es_dest,
  output logic                  es_gr_we,
  output logic                  es_mem_we,
  output logic                  es_res_from_mem,
  output logic                  es_fwd_valid,
  output logic [DEST_W-1:0]     es_fwd_dest,
  output logic [31:0]           es_fwd_data,
  output logic                  es_load_hazard,
  output logic                  es_ctrl_err
);

  typedef struct packed {
    logic [ALU_CTRL_W-1:0] ctrl;
    logic [31:0]           src1;
    logic [31:0]           src2;
    logic [31:0]           pc;
    logic [31:0]           store_data;
    logic [DEST_W-1:0]     dest;
    logic                  gr_we;
    logic                  mem_we;
    logic                  res_from_mem;
  } bundle_t;

  bundle_t ds_b, es_b;
  logic    es_valid;
  logic    es_ready_go;
  logic    accept;
  logic    ctrl_bad;

  assign ds_b = '{ctrl: ds_alu_control, src1: ds_src1, src2: ds_src2, pc: ds_pc,
                  store_data: ds_store_data, dest: ds_dest, gr_we: ds_gr_we,
                  mem_we: ds_mem_we, res_from_mem: ds_res_from_mem};

  // Single-cycle ALU: the stage is always ready to hand off.
  assign es_ready_go = 1'b1;
  assign es_allowin  = !es_valid || (es_ready_go && ms_allowin);
  assign accept      = ds_to_es_valid && es_allowin && !flush;
  assign ctrl_bad    = ($countones(ds_alu_control) != 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid    <= 1'b0;
      es_b        <= '0;
      es_ctrl_err <= 1'b0;
    end else begin
      if (flush)           es_valid <= 1'b0;
      else if (es_allowin) es_valid <= ds_to_es_valid;
      if (accept) begin
        es_b <= ds_b;
        if (ctrl_bad) es_ctrl_err <= 1'b1;
      end
    end
  end

  assign es_to_ms_valid  = es_valid && es_ready_go && !flush;
  assign alu_control     = es_valid ? es_b.ctrl : '0;
  assign alu_rj          = es_b.src1;
  assign alu_rk          = es_b.src2;

  assign es_pc           = es_b.pc;
  assign es_result       = alu_result;
  assign es_store_data   = es_b.store_data;
  assign es_dest         = es_b.dest;
  assign es_gr_we        = es_b.gr_we;
  assign es_mem_we       = es_b.mem_we;
  assign es_res_from_mem = es_b.res_from_mem;

  // Bypass only when the held instruction really writes a non-zero register.
  assign es_fwd_valid    = es_valid && es_b.gr_we && (es_b.dest != '0);
  assign es_fwd_dest     = es_b.dest;
  assign es_fwd_data     = alu_result;
  assign es_load_hazard  = es_fwd_valid && es_b.res_from_mem;

endmodule

// File: tb/tb_exe_stage.sv
// Randomized bench for exe_stage: a slot-level model of the stage plus a few
// hand-computed directed scenarios; a combinational ALU stand-in feeds alu_result.
module tb_exe_stage;
  localparam int CW = 12;
  localparam int DW = 5;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [31:0]   src1, src2, pc, sd;
    logic [DW-1:0] dest;
    logic          gr_we, mem_we, rfm;
  } bundle_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, flush, ds_to_es_valid, ms_allowin;
  bundle_t       in_b;
  logic          es_allowin, es_to_ms_valid;
  logic [CW-1:0] alu_control;
  logic [31:0]   alu_rj, alu_rk, alu_result;
  logic [31:0]   es_pc, es_result, es_store_data, es_fwd_data;
  logic [DW-1:0] es_dest, es_fwd_dest;
  logic          es_gr_we, es_mem_we, es_res_from_mem;
  logic          es_fwd_valid, es_load_hazard, es_ctrl_err;

  int n_cmp = 0;
  int n_err = 0;

  exe_stage #(.ALU_CTRL_W(CW), .DEST_W(DW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
    .ds_alu_control(in_b.ctrl), .ds_src1(in_b.src1), .ds_src2(in_b.src2),
    .ds_pc(in_b.pc), .ds_store_data(in_b.sd), .ds_dest(in_b.dest),
    .ds_gr_we(in_b.gr_we), .ds_mem_we(in_b.mem_we), .ds_res_from_mem(in_b.rfm),
    .alu_control(alu_control), .alu_rj(alu_rj), .alu_rk(alu_rk),
    .alu_result(alu_result), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_result(es_result), .es_store_data(es_store_data),
    .es_dest(es_dest), .es_gr_we(es_gr_we), .es_mem_we(es_mem_we),
    .es_res_from_mem(es_res_from_mem), .es_fwd_valid(es_fwd_valid),
    .es_fwd_dest(es_fwd_dest), .es_fwd_data(es_fwd_data),
    .es_load_hazard(es_load_hazard), .es_ctrl_err(es_ctrl_err)
  );

  // ALU stand-in: add on bit 11, sub on bit 10, xor otherwise.
  function automatic logic [31:0] alu_fn(logic [CW-1:0] c, logic [31:0] a, logic [31:0] b);
    if (c[11])      return a + b;
    else if (c[10]) return a - b;
    else            return a ^ b;
  endfunction
  assign alu_result = alu_fn(alu_control, alu_rj, alu_rk);

  // Model: the stage is a slot that is either empty or holds one bundle.
  logic    slot_full;
  bundle_t slot;
  logic    err_seen;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_full <= 1'b0;
      slot      <= '0;
      err_seen  <= 1'b0;
    end else if (flush) begin
      slot_full <= 1'b0;
    end else if (!slot_full || ms_allowin) begin
      slot_full <= ds_to_es_valid;
      if (ds_to_es_valid) begin
        slot <= in_b;
        if ($countones(in_b.ctrl) != 1) err_seen <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [CW-1:0] ec;
    logic          fv;
    ec = slot_full ? slot.ctrl : '0;
    fv = slot_full && slot.gr_we && (slot.dest != 0);
    check("allowin",     64'(es_allowin),     64'(!slot_full || ms_allowin));
    check("to_ms_valid", 64'(es_to_ms_valid), 64'(slot_full && !flush));
    check("alu_control", 64'(alu_control),    64'(ec));
    check("alu_rj",      64'(alu_rj),         64'(slot.src1));
    check("alu_rk",      64'(alu_rk),         64'(slot.src2));
    check("es_result",   64'(es_result),      64'(alu_fn(ec, slot.src1, slot.src2)));
    check("es_pc",       64'(es_pc),          64'(slot.pc));
    check("store_data",  64'(es_store_data),  64'(slot.sd));
    check("es_dest",     64'(es_dest),        64'(slot.dest));
    check("flags",       64'({es_gr_we, es_mem_we, es_res_from_mem}),
                         64'({slot.gr_we, slot.mem_we, slot.rfm}));
    check("fwd_valid",   64'(es_fwd_valid),   64'(fv));
    check("fwd_dest",    64'(es_fwd_dest),    64'(slot.dest));
    check("fwd_data",    64'(es_fwd_data),    64'(alu_fn(ec, slot.src1, slot.src2)));
    check("load_hazard", 64'(es_load_hazard), 64'(fv && slot.rfm));
    check("ctrl_err",    64'(es_ctrl_err),    64'(err_seen));
  end

  function automatic bundle_t mk(logic [31:0] pc, logic [31:0] a, logic [31:0] b,
                                 logic [CW-1:0] c, logic [DW-1:0] d, logic gr, logic rfm);
    bundle_t r;
    r = '{ctrl: c, src1: a, src2: b, pc: pc, sd: pc ^ 32'h5a5a0000, dest: d,
          gr_we: gr, mem_we: 1'b0, rfm: rfm};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b1; flush = 1'b0; ds_to_es_valid = 1'b0; ms_allowin = 1'b0; in_b = '0;
    #1 resetn = 1'b0;
    @(negedge clk);
    check("rst_allowin", 64'(es_allowin), 64'd1);
    check("rst_tmv",     64'(es_to_ms_valid), 64'd0);
    check("rst_ctrl",    64'(alu_control), 64'd0);
    check("rst_err",     64'(es_ctrl_err), 64'd0);
    step(); resetn = 1'b1;

    // Add 5+7 into r3
    in_b = mk(32'h100, 5, 7, 12'h800, 3, 1, 0); ds_to_es_valid = 1'b1; ms_allowin = 1'b1;
    step(); ds_to_es_valid = 1'b0; ms_allowin = 1'b0;
    @(negedge clk);
    check("add_tmv",      64'(es_to_ms_valid), 64'd1);
    check("add_result",   64'(es_result), 64'd12);
    check("add_fwd",      64'(es_fwd_valid), 64'd1);
    check("add_fwd_dest", 64'(es_fwd_dest), 64'd3);

    // Stall three cycles while ID offers the next bundle
    in_b = mk(32'h200, 20, 3, 12'h400, 6, 1, 0); ds_to_es_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      check("stall_allowin", 64'(es_allowin), 64'd0);
      check("stall_pc",      64'(es_pc), 64'h100);
      check("stall_result",  64'(es_result), 64'd12);
    end
    ms_allowin = 1'b1;
    step(); ds_to_es_valid = 1'b0;
    @(negedge clk);
    check("b2b_pc",     64'(es_pc), 64'h200);
    check("b2b_result", 64'(es_result), 64'd17);
    check("b2b_tmv",    64'(es_to_ms_valid), 64'd1);

    // Flush with a simultaneous offer
    flush = 1'b1; in_b = mk(32'h300, 1, 2, 12'h000, 7, 1, 0); ds_to_es_valid = 1'b1;
    @(negedge clk);
    check("flush_tmv", 64'(es_to_ms_valid), 64'd0);
    step(); flush = 1'b0; ds_to_es_valid = 1'b0;
    @(negedge clk);
    check("post_flush_tmv", 64'(es_to_ms_valid), 64'd0);
    check("post_flush_pc",  64'(es_pc), 64'h200);
    check("post_flush_err", 64'(es_ctrl_err), 64'd0);

    // Load hazard, then the same load targeting r0
    in_b = mk(32'h400, 100, 8, 12'h800, 4, 1, 1); ds_to_es_valid = 1'b1;
    step(); in_b.dest = 0; in_b.pc = 32'h404;
    @(negedge clk);
    check("ld_hazard", 64'(es_load_hazard), 64'd1);
    step(); ds_to_es_valid = 1'b0;
    @(negedge clk);
    check("ld_r0_fwd",    64'(es_fwd_valid), 64'd0);
    check("ld_r0_hazard", 64'(es_load_hazard), 64'd0);

    // Malformed controls: none, then two bits
    in_b = mk(32'h500, 9, 4, 12'h000, 2, 1, 0); ds_to_es_valid = 1'b1;
    step(); in_b = mk(32'h504, 9, 4, 12'h820, 2, 1, 0);
    @(negedge clk);
    check("err_first", 64'(es_ctrl_err), 64'd1);
    check("err_xor",   64'(es_result), 64'd13);
    step(); in_b = mk(32'h508, 9, 4, 12'h800, 2, 1, 0);
    @(negedge clk);
    check("err_sticky", 64'(es_ctrl_err), 64'd1);
    check("err_add",    64'(es_result), 64'd13);

    // Async reset between edges while stalled
    step(); ds_to_es_valid = 1'b0; ms_allowin = 1'b0;
    @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    check("arst_tmv",     64'(es_to_ms_valid), 64'd0);
    check("arst_allowin", 64'(es_allowin), 64'd1);
    check("arst_ctrl",    64'(alu_control), 64'd0);
    check("arst_pc",      64'(es_pc), 64'd0);
    check("arst_err",     64'(es_ctrl_err), 64'd0);
    step(); resetn = 1'b1;
    in_b = mk(32'h600, 1, 1, 12'h800, 1, 1, 0); ds_to_es_valid = 1'b1; ms_allowin = 1'b1;
    step(); ds_to_es_valid = 1'b0;
    @(negedge clk);
    check("rel_tmv",    64'(es_to_ms_valid), 64'd1);
    check("rel_result", 64'(es_result), 64'd2);
    check("rel_err",    64'(es_ctrl_err), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      flush          = ($urandom_range(0, 9) == 0);
      ds_to_es_valid = ($urandom_range(0, 3) != 0);
      ms_allowin     = ($urandom_range(0, 2) != 0);
      in_b.src1 = $urandom; in_b.src2 = $urandom; in_b.pc = $urandom; in_b.sd = $urandom;
      in_b.dest = DW'($urandom_range(0, 3));
      {in_b.gr_we, in_b.mem_we, in_b.rfm} = 3'($urandom);
      if ($urandom_range(0, 15) == 0) in_b.ctrl = CW'($urandom);
      else                            in_b.ctrl = CW'(1) << $urandom_range(0, CW - 1);
      if (i == 1500) resetn = 1'b0;
      if (i == 1502) resetn = 1'b1;
      step();
    end
    flush = 1'b0; ds_to_es_valid = 1'b0;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
